// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch stage's bus, redirect and decode-side handshake signals.
//   ireq_valid/ireq_addr       : instruction-bus request (fetch -> bus)
//   iresp_data_ok/iresp_data   : instruction-bus response (bus -> fetch)
//   redirect_valid/redirect_pc : PC redirect from execute
//   out_valid/out_ready        : valid/ready handshake toward decode
//   out_pc/out_instr/out_misalign : head entry of the fetch queue
// modport master : the fetch stage itself
// modport slave  : its environment (bus, execute, decode)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_data_ok, iresp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_pc, out_instr, out_misalign,
        input  out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_data_ok, iresp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_pc, out_instr, out_misalign,
        output out_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage feeding the decoder. Holds the PC, runs one
// instruction-bus transaction at a time and buffers returned words in a
// 2-entry (pc, instr, misalign) queue presented through a valid/ready port.
// Redirects from execute flush the queue and discard wrong-path words,
// including a response that is still in flight (DRAIN state).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   fif   : fetch_stage_if.master (bus request/response, redirect, decode port)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic        run_reg;      // low until the first edge after reset release
    logic [63:0] pc_reg;       // fetch PC; in DRAIN it is the abandoned address
    logic [63:0] target_reg;   // redirect target latched while draining
    logic        head_reg;
    logic [1:0]  count_reg;

    logic [63:0] q_pc_reg    [QDEPTH];
    logic [31:0] q_instr_reg [QDEPTH];
    logic        q_mis_reg   [QDEPTH];

    logic        aligned;
    logic        req_valid;
    logic        accept;
    logic        flush;
    logic        pop;
    logic        push_data;
    logic        push_mis;
    logic        push;
    logic        tail;
    logic [31:0] push_instr;

    assign aligned = (pc_reg[1:0] == 2'b00);

    // No request in the reset-release cycle, so a stale strobe arriving
    // right after reset can never be mistaken for a response.
    assign req_valid = run_reg &&
                       (((state_reg == ST_FETCH) && (count_reg < 2'd2) && aligned) ||
                        (state_reg == ST_DRAIN));

    assign accept = req_valid && fif.iresp_data_ok;
    assign flush  = fif.redirect_valid;
    assign pop    = (count_reg != 2'd0) && fif.out_ready && !flush;

    // In FETCH a live request implies an aligned PC, so accept alone marks data.
    assign push_data  = !flush && (state_reg == ST_FETCH) && accept;
    assign push_mis   = !flush && run_reg && (state_reg == ST_FETCH) && !aligned &&
                        (count_reg < 2'd2);
    assign push       = push_data || push_mis;
    assign push_instr = push_mis ? 32'h0 : fif.iresp_data;

    // Pushes only happen at count<2, so the free slot is head+count.
    assign tail = head_reg ^ count_reg[0];

    assign fif.ireq_valid   = req_valid;
    assign fif.ireq_addr    = req_valid ? pc_reg : 64'h0;
    assign fif.out_valid    = (count_reg != 2'd0);
    assign fif.out_pc       = (count_reg != 2'd0) ? q_pc_reg[head_reg]    : 64'h0;
    assign fif.out_instr    = (count_reg != 2'd0) ? q_instr_reg[head_reg] : 32'h0;
    assign fif.out_misalign = (count_reg != 2'd0) ? q_mis_reg[head_reg]   : 1'b0;

    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_pc_reg[gi]    <= 64'h0;
                    q_instr_reg[gi] <= 32'h0;
                    q_mis_reg[gi]   <= 1'b0;
                end else if (push && (tail == 1'(gi))) begin
                    q_pc_reg[gi]    <= pc_reg;
                    q_instr_reg[gi] <= push_instr;
                    q_mis_reg[gi]   <= push_mis;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_FETCH;
            run_reg    <= 1'b0;
            pc_reg     <= RESET_PC;
            target_reg <= 64'h0;
            head_reg   <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            run_reg <= 1'b1;
            if (flush) begin
                head_reg  <= 1'b0;
                count_reg <= 2'd0;
                if (req_valid && !fif.iresp_data_ok) begin
                    // Response still owed: keep the request up, finish it later.
                    target_reg <= fif.redirect_pc;
                    state_reg  <= ST_DRAIN;
                end else begin
                    pc_reg    <= fif.redirect_pc;
                    state_reg <= ST_FETCH;
                end
            end else begin
                count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                head_reg  <= head_reg ^ pop;
                case (state_reg)
                    ST_FETCH: begin
                        if (push_data) begin
                            pc_reg <= pc_reg + 64'd4;
                        end
                        if (push_mis) begin
                            state_reg <= ST_HALT;
                        end
                    end
                    ST_DRAIN: begin
                        if (accept) begin
                            pc_reg    <= target_reg;
                            state_reg <= ST_FETCH;
                        end
                    end
                    ST_HALT: begin
                        state_reg <= ST_HALT;
                    end
                    default: begin
                        state_reg <= ST_FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if fif ();

    fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // stimulus knobs
    int          wait_knob   = 2;    // -1: random response latency
    bit          rdy_rand    = 1'b0;
    bit          rdy_val     = 1'b0;
    bit          redir_rand  = 1'b0;
    bit          redir_now   = 1'b0;
    bit          redir_on_ok = 1'b0;
    bit          stray_once  = 1'b0;
    bit          stray_rand  = 1'b0;
    logic [63:0] redir_tgt   = 64'h0;

    // reference model state
    bit          busy   = 1'b0;
    bit          stale  = 1'b0;
    int          wcnt   = 0;
    logic [63:0] b_addr = 64'h0;
    logic [63:0] exp_pc = RESET_PC;

    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == RESET_PC) return 32'h0000_0013;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] rand_tgt();
        logic [63:0] t;
        case ($urandom_range(0, 7))
            0:       t = 64'hFFFF_FFFF_FFFF_FFF4;
            1:       t = {$urandom, $urandom} & ~64'h3;
            2:       t = RESET_PC + 64'($urandom_range(0, 63) * 4) + 64'($urandom_range(1, 3));
            default: t = RESET_PC + 64'($urandom_range(0, 255) * 4);
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Bus responder, redirect source, decode ready, and expected-stream model.
    always @(negedge clk) begin
        logic        rq, ok, rv;
        logic [63:0] tgt;
        if (reset) begin
            fif.iresp_data_ok  = 1'b0;
            fif.iresp_data     = 32'h0;
            fif.redirect_valid = 1'b0;
            fif.redirect_pc    = 64'h0;
            fif.out_ready      = 1'b0;
            exp_q.delete();
            exp_pc = RESET_PC;
            busy   = 1'b0;
            stale  = 1'b0;
        end else begin
            rq  = fif.ireq_valid;
            ok  = 1'b0;
            rv  = 1'b0;
            tgt = redir_tgt;
            fif.iresp_data = $urandom;
            if (rq) begin
                if (!busy) begin
                    busy   = 1'b1;
                    stale  = 1'b0;
                    b_addr = fif.ireq_addr;
                    wcnt   = (wait_knob < 0) ? int'($urandom_range(0, 3)) : wait_knob;
                    chk("req_addr", fif.ireq_addr, exp_pc);
                    chk("req_aligned", 64'(fif.ireq_addr[1:0]), 64'h0);
                end else begin
                    chk("req_stable", fif.ireq_addr, b_addr);
                end
                if (wcnt == 0) begin
                    ok = 1'b1;
                    fif.iresp_data = mem(b_addr);
                end else begin
                    wcnt--;
                end
            end else if (stray_once || (stray_rand && $urandom_range(0, 7) == 0)) begin
                ok = 1'b1;
                fif.iresp_data = 32'hDEAD_BEEF;
                stray_once = 1'b0;
            end
            if (redir_now || (redir_on_ok && rq && ok)) begin
                rv = 1'b1;
                redir_now   = 1'b0;
                redir_on_ok = 1'b0;
            end else if (redir_rand && $urandom_range(0, 15) == 0) begin
                rv  = 1'b1;
                tgt = rand_tgt();
            end
            // Expected decode stream: sequential words from the current
            // correct-path PC; a redirect wipes everything not yet consumed.
            if (rv) begin
                exp_q.delete();
                exp_pc = tgt;
                if (rq && ok) busy = 1'b0;
                else if (rq)  stale = 1'b1;
                if (tgt[1:0] != 2'b00) exp_q.push_back('{pc: tgt, instr: 32'h0, mis: 1'b1});
            end else if (rq && ok) begin
                busy = 1'b0;
                if (!stale) begin
                    exp_q.push_back('{pc: exp_pc, instr: mem(exp_pc), mis: 1'b0});
                    exp_pc = exp_pc + 64'd4;
                end
            end
            fif.out_ready      = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
            fif.iresp_data_ok  = ok;
            fif.redirect_valid = rv;
            fif.redirect_pc    = tgt;
        end
    end

    // Monitor: compares every accepted decode transfer with the scoreboard.
    always @(negedge clk) begin
        ent_t e;
        #1;
        if (!reset && fif.out_valid && fif.out_ready && !fif.redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got pc %h instr %h want no entry", fif.out_pc, fif.out_instr);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", fif.out_pc, e.pc);
                chk("out_instr", 64'(fif.out_instr), 64'(e.instr));
                chk("out_misalign", 64'(fif.out_misalign), 64'(e.mis));
                $display("pop pc=%h instr=%h mis=%0d", fif.out_pc, fif.out_instr, fif.out_misalign);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hold, cnt;
        reset = 1'b1;
        step(3);
        chk("rst_ireq_valid", 64'(fif.ireq_valid), 64'h0);
        chk("rst_out_valid", 64'(fif.out_valid), 64'h0);
        chk("rst_out_pc", fif.out_pc, 64'h0);
        chk("rst_out_instr", 64'(fif.out_instr), 64'h0);
        chk("rst_out_misalign", 64'(fif.out_misalign), 64'h0);

        // first fetch, response 2 cycles late, decode stalled
        wait_knob = 2;
        rdy_val   = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        step(1);
        while (!fif.ireq_valid && n < 10) begin step(1); n++; end
        chk("first_req_addr", fif.ireq_addr, RESET_PC);
        hold = 0;
        while (fif.ireq_valid && fif.ireq_addr == RESET_PC && hold < 10) begin step(1); hold++; end
        chk("first_req_hold", 64'(hold), 64'd3);
        chk("first_out_valid", 64'(fif.out_valid), 64'h1);
        chk("first_out_pc", fif.out_pc, RESET_PC);
        chk("first_out_instr", 64'(fif.out_instr), 64'h13);
        chk("second_req_addr", fif.ireq_addr, RESET_PC + 64'd4);

        // backpressure: queue fills, requests stop
        wait_knob = 0;
        n = 0;
        while (fif.ireq_valid && n < 10) begin step(1); n++; end
        step(3);
        chk("full_no_req", 64'(fif.ireq_valid), 64'h0);
        chk("full_out_valid", 64'(fif.out_valid), 64'h1);
        chk("full_head_pc", fif.out_pc, RESET_PC);
        wait_knob = 3;
        rdy_val = 1'b1;
        step(1);
        rdy_val = 1'b0;
        step(1);
        chk("pop_req_valid", 64'(fif.ireq_valid), 64'h1);
        chk("pop_req_addr", fif.ireq_addr, RESET_PC + 64'd8);
        chk("pop_head_pc", fif.out_pc, RESET_PC + 64'd4);

        // redirect while the request is waiting
        redir_tgt = 64'h8000_0100;
        redir_now = 1'b1;
        step(2);
        chk("drain_out_valid", 64'(fif.out_valid), 64'h0);
        chk("drain_req_valid", 64'(fif.ireq_valid), 64'h1);
        chk("drain_req_addr", fif.ireq_addr, RESET_PC + 64'd8);
        n = 0;
        cnt = 0;
        while (fif.ireq_addr != 64'h8000_0100 && n < 10) begin
            if (fif.out_valid) cnt++;
            step(1);
            n++;
        end
        chk("drain_empty_cycles", 64'(cnt), 64'h0);
        chk("redirect_req_addr", fif.ireq_addr, 64'h8000_0100);

        // redirect coinciding with the response strobe
        redir_tgt   = 64'h8000_0200;
        redir_on_ok = 1'b1;
        n = 0;
        while (fif.ireq_addr != 64'h8000_0200 && n < 10) begin step(1); n++; end
        chk("okredir_req_addr", fif.ireq_addr, 64'h8000_0200);
        chk("okredir_out_valid", 64'(fif.out_valid), 64'h0);

        // misaligned redirect produces a marker and halts
        rdy_val   = 1'b1;
        wait_knob = 1;
        redir_tgt = 64'h8000_0102;
        redir_now = 1'b1;
        n = 0;
        step(1);
        while (!(fif.out_valid && fif.out_misalign) && n < 20) begin step(1); n++; end
        chk("mis_flag", 64'(fif.out_misalign), 64'h1);
        chk("mis_pc", fif.out_pc, 64'h8000_0102);
        chk("mis_instr", 64'(fif.out_instr), 64'h0);
        cnt = 0;
        repeat (6) begin step(1); if (fif.ireq_valid) cnt++; end
        chk("halt_idle", 64'(cnt), 64'h0);
        redir_tgt = 64'h8000_0300;
        redir_now = 1'b1;
        n = 0;
        step(1);
        while (!fif.ireq_valid && n < 10) begin step(1); n++; end
        chk("resume_req_addr", fif.ireq_addr, 64'h8000_0300);

        // reset in the middle of a drain
        wait_knob = 6;
        n = 0;
        while (fif.ireq_addr != 64'h8000_0304 && n < 10) begin step(1); n++; end
        redir_tgt = 64'h8000_0400;
        redir_now = 1'b1;
        step(2);
        chk("rdrain_req_addr", fif.ireq_addr, 64'h8000_0304);
        reset = 1'b1;
        #1;
        chk("rdrain_ireq_valid", 64'(fif.ireq_valid), 64'h0);
        chk("rdrain_out_valid", 64'(fif.out_valid), 64'h0);
        chk("rdrain_out_pc", fif.out_pc, 64'h0);
        step(2);
        wait_knob  = 2;
        stray_once = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        step(1);
        while (!fif.ireq_valid && n < 10) begin step(1); n++; end
        chk("rdrain_restart_addr", fif.ireq_addr, RESET_PC);
        n = 0;
        while (!fif.out_valid && n < 10) begin step(1); n++; end
        chk("rdrain_out_pc2", fif.out_pc, RESET_PC);
        chk("rdrain_out_instr", 64'(fif.out_instr), 64'h13);

        // randomized traffic with a reset partway through
        wait_knob  = -1;
        rdy_rand   = 1'b1;
        redir_rand = 1'b1;
        stray_rand = 1'b1;
        step(1500);
        reset = 1'b1;
        #1;
        chk("rand_rst_out_valid", 64'(fif.out_valid), 64'h0);
        chk("rand_rst_req_valid", 64'(fif.ireq_valid), 64'h0);
        step(2);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1500);
        redir_rand = 1'b0;
        rdy_rand   = 1'b0;
        rdy_val    = 1'b1;
        step(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
